// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store access size encodings used by the LSU.
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

endpackage

// File: rtl/riscv_lsu.sv
// Load/store unit: byte-lane steering and load extension, plus a one-bit stall handshake.
// Optional concurrent assertions are compiled in when RISCV_LSU_SVA_EN is defined.
module riscv_lsu
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    logic        stall_q;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign mem_req_o  = core_req_i;
    assign mem_we_o   = core_we_i;
    assign mem_addr_o = core_addr_i;

    // Ready only counts once the request has been held for at least one cycle.
    assign core_stall_o = core_req_i & ~(stall_q & mem_ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= core_stall_o;
        end
    end

    always_comb begin
        mem_be_o = 4'b1111;
        mem_wd_o = '0;
        case (core_size_i)
            LDST_B: begin
                mem_be_o = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
            end
            LDST_H: begin
                mem_be_o = core_addr_i[1] ? 4'b1100 : 4'b0011;
                mem_wd_o = {2{core_wd_i[15:0]}};
            end
            LDST_W: begin
                mem_wd_o = core_wd_i;
            end
            LDST_BU: mem_be_o = 4'b0001 << core_addr_i[1:0];
            LDST_HU: mem_be_o = core_addr_i[1] ? 4'b1100 : 4'b0011;
            default: ;
        endcase
    end

    always_comb begin
        rd_byte = mem_rd_i[7:0];
        case (core_addr_i[1:0])
            2'd0: rd_byte = mem_rd_i[7:0];
            2'd1: rd_byte = mem_rd_i[15:8];
            2'd2: rd_byte = mem_rd_i[23:16];
            2'd3: rd_byte = mem_rd_i[31:24];
            default: ;
        endcase
        rd_half = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    end

    always_comb begin
        core_rd_o = '0;
        case (core_size_i)
            LDST_B:  core_rd_o = {{24{rd_byte[7]}}, rd_byte};
            LDST_BU: core_rd_o = {24'd0, rd_byte};
            LDST_H:  core_rd_o = {{16{rd_half[15]}}, rd_half};
            LDST_HU: core_rd_o = {16'd0, rd_half};
            LDST_W:  core_rd_o = mem_rd_i;
            default: ;
        endcase
    end

`ifdef RISCV_LSU_SVA_EN
    a_stall_needs_req : assert property (@(posedge clk_i) disable iff (rst_i)
        core_stall_o |-> core_req_i);
    a_new_req_stalls : assert property (@(posedge clk_i) disable iff (rst_i)
        $rose(core_req_i) |-> $rose(core_stall_o));
    a_req_passthru : assert property (@(posedge clk_i) disable iff (rst_i)
        mem_req_o == core_req_i);
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: per-cycle reference model plus hand-computed vectors.
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int n_pass  = 0;
    int n_total = 0;

    riscv_lsu dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: lanes from plain byte arithmetic, stall from the count of cycles waited.
    function automatic logic [31:0] model_rd(input logic [2:0] size, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        int          sb;
        int          sh;
        b  = 8'(word >> (8 * int'(addr[1:0])));
        h  = 16'(word >> (16 * int'(addr[1])));
        sb = int'(b);
        sh = int'(h);
        if (b >= 8'd128)     sb = sb - 256;
        if (h >= 16'd32768)  sh = sh - 65536;
        case (size)
            3'd0: return 32'(sb);
            3'd4: return 32'(b);
            3'd1: return 32'(sh);
            3'd5: return 32'(h);
            3'd2: return word;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] size, input logic [31:0] addr);
        if (size == 3'd0 || size == 3'd4) return 4'(1 << int'(addr[1:0]));
        if (size == 3'd1 || size == 3'd5) return addr[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] size, input logic [31:0] wd);
        if (size == 3'd0) return wd[7:0] * 32'h0101_0101;
        if (size == 3'd1) return wd[15:0] * 32'h0001_0001;
        if (size == 3'd2) return wd;
        return 32'd0;
    endfunction

    int   waited = 0;
    logic exp_stall = 1'b0;

    always @(negedge clk_i) begin
        exp_stall = core_req_i && !(waited > 0 && mem_ready_i);
        check("stall",    32'(core_stall_o), 32'(exp_stall));
        check("mem_req",  32'(mem_req_o),    32'(core_req_i));
        check("mem_we",   32'(mem_we_o),     32'(core_we_i));
        check("mem_addr", mem_addr_o,        core_addr_i);
        check("mem_be",   32'(mem_be_o),     32'(model_be(core_size_i, core_addr_i)));
        check("mem_wd",   mem_wd_o,          model_wd(core_size_i, core_wd_i));
        check("core_rd",  core_rd_o,         model_rd(core_size_i, core_addr_i, mem_rd_i));
    end

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) waited <= 0;
        else       waited <= exp_stall ? waited + 1 : 0;
    end

    task automatic drive(input logic req, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input logic rdy);
        @(posedge clk_i);
        #1;
        core_req_i  = req;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_rd_i    = rd;
        mem_ready_i = rdy;
        @(negedge clk_i);
    endtask

    task automatic set_ready(input logic rdy);
        @(posedge clk_i);
        #1;
        mem_ready_i = rdy;
        @(negedge clk_i);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 32'h0000_1000, 32'h0,         32'h1122_3344};
        vecs[1]  = '{1'b0, 3'd0, 32'h0000_1002, 32'h0,         32'h11C2_3344};
        vecs[2]  = '{1'b0, 3'd4, 32'h0000_1003, 32'h0,         32'hF122_3344};
        vecs[3]  = '{1'b0, 3'd1, 32'h0000_1000, 32'h0,         32'h1234_8001};
        vecs[4]  = '{1'b0, 3'd1, 32'h0000_1001, 32'h0,         32'h1234_8001};
        vecs[5]  = '{1'b0, 3'd5, 32'h0000_1000, 32'h0,         32'h1234_8001};
        vecs[6]  = '{1'b0, 3'd2, 32'h0000_1003, 32'h0,         32'hDEAD_BEEF};
        vecs[7]  = '{1'b0, 3'd3, 32'h0000_1000, 32'h0,         32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 3'd2, 32'h0000_2000, 32'hCAFE_F00D, 32'h0};
        vecs[9]  = '{1'b1, 3'd4, 32'h0000_2002, 32'h0000_00AB, 32'h0};
        vecs[10] = '{1'b1, 3'd7, 32'h0000_2001, 32'h1234_5678, 32'h0};
        vecs[11] = '{1'b1, 3'd0, 32'h0000_2003, 32'h0000_0077, 32'h0};

        rst_i = 1'b1;
        core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
        core_addr_i = '0; core_wd_i = '0; mem_rd_i = '0; mem_ready_i = 1'b0;

        // During reset the stall follows req directly.
        drive(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 32'h0, 1'b1);
        check("lit_reset_stall", 32'(core_stall_o), 32'd1);

        @(posedge clk_i); #1;
        rst_i = 1'b0; core_req_i = 1'b0;
        @(negedge clk_i);
        check("lit_post_reset_idle", 32'(core_stall_o), 32'd0);

        drive(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1'b0);
        check("lit_lb_signed", core_rd_o, 32'hFFFF_FF80);
        drive(1'b1, 1'b0, 3'd5, 32'h0000_0102, 32'h0, 32'h9ABC_0000, 1'b0);
        check("lit_lhu", core_rd_o, 32'h0000_9ABC);
        drive(1'b1, 1'b1, 3'd0, 32'h0000_0201, 32'h1234_56A5, 32'h0, 1'b0);
        check("lit_sb_be", 32'(mem_be_o), 32'h2);
        check("lit_sb_wd", mem_wd_o, 32'hA5A5_A5A5);
        drive(1'b1, 1'b1, 3'd1, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 1'b0);
        check("lit_sh_be", 32'(mem_be_o), 32'hC);
        check("lit_sh_wd", mem_wd_o, 32'hBEEF_BEEF);

        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd, vecs[i].rd,
                  1'(i % 2));
        end

        drive(1'b0, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 1'b1);
        check("lit_idle_no_stall", 32'(core_stall_o), 32'd0);

        // Handshake: request cycle plus two more waits with ready low, then ready.
        drive(1'b1, 1'b0, 3'd2, 32'h0000_3000, 32'h0, 32'h5555_AAAA, 1'b0);
        check("lit_hs_c0", 32'(core_stall_o), 32'd1);
        set_ready(1'b0);
        check("lit_hs_c1", 32'(core_stall_o), 32'd1);
        set_ready(1'b0);
        check("lit_hs_c2", 32'(core_stall_o), 32'd1);
        set_ready(1'b1);
        check("lit_hs_release", 32'(core_stall_o), 32'd0);
        set_ready(1'b1);
        check("lit_b2b_restall", 32'(core_stall_o), 32'd1);
        set_ready(1'b1);
        check("lit_b2b_release", 32'(core_stall_o), 32'd0);

        // Reset in the middle of a stall, request held throughout.
        drive(1'b0, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 3'd2, 32'h0000_4000, 32'h0, 32'h0, 1'b0);
        check("lit_rst_pre", 32'(core_stall_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b1; mem_ready_i = 1'b1;
        @(negedge clk_i);
        check("lit_rst_mid", 32'(core_stall_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("lit_rst_restall", 32'(core_stall_o), 32'd1);
        set_ready(1'b1);
        check("lit_rst_release", 32'(core_stall_o), 32'd0);

        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        @(posedge clk_i); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
